mem_ext_arbiter: RTL and testbench

Round-robin arbiter sharing the single write port (W0) and single read port (R0) of the behavioural `mem_ext` backing SRAM between `NUM_REQ` requesters, e.g. core refill/writeback and a testbench loader. Each cycle it grants at most one write and one read, resolves same-address read/write collisions, and routes each 1-cycle-latency read response back to its issuer. It sits directly in front of `mem_ext` in the test harness. All memory-side outputs are registered-free combinational drives of `mem_ext` inputs.

---
 rtl/mem_ext_arb_pkg.sv | 20 ++
 rtl/mem_ext_arb_if.sv | 36 +++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/mem_ext_arbiter.sv | 108 ++++++++++
 tb/tb_mem_ext_arbiter.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/mem_ext_arb_pkg.sv
// Shared constants and request record for the mem_ext port arbiter.
package mem_ext_arb_pkg;

  localparam int unsigned ADDR_W     = 26;
  localparam int unsigned DATA_W     = 256;
  localparam int unsigned MASK_W     = DATA_W / 8;
  localparam int unsigned PERF_CNT_W = 32;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } mem_req_t;

  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] x);
    return (x == '1) ? x : x + 1'b1;
  endfunction

endpackage

// File: rtl/mem_ext_arb_if.sv
// Requester and mem_ext-side signals of the arbiter; slave = arbiter view.
interface mem_ext_arb_if
  import mem_ext_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) ();

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*MASK_W-1:0] req_mask;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_data;
  logic                      mem_w_en;
  logic [ADDR_W-1:0]         mem_w_addr;
  logic [DATA_W-1:0]         mem_w_data;
  logic [MASK_W-1:0]         mem_w_mask;
  logic                      mem_r_en;
  logic [ADDR_W-1:0]         mem_r_addr;
  logic [DATA_W-1:0]         mem_r_data;

  modport slave (
    input  req_valid, req_write, req_addr, req_data, req_mask, mem_r_data,
    output req_ready, resp_valid, resp_data,
    output mem_w_en, mem_w_addr, mem_w_data, mem_w_mask, mem_r_en, mem_r_addr
  );

  modport master (
    output req_valid, req_write, req_addr, req_data, req_mask, mem_r_data,
    input  req_ready, resp_valid, resp_data,
    input  mem_w_en, mem_w_addr, mem_w_data, mem_w_mask, mem_r_en, mem_r_addr
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at ptr+1, ptr moves to the winner only on advance.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] gnt_idx;

  always_comb begin
    int unsigned idx;
    gnt     = '0;
    gnt_idx = ptr_q;
    idx     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      if (req[idx] && (gnt == '0)) begin
        gnt[idx] = 1'b1;
        gnt_idx  = PtrW'(idx);
      end
    end
  end

  // Separate process so the advance -> ptr path never loops back into gnt.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && (gnt != '0)) ptr_d = gnt_idx;
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= PtrW'(N - 1);
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_ext_arbiter.sv
// Shares mem_ext W0/R0 between NUM_REQ requesters; perf counters under MEM_EXT_ARB_PERF_EN.
module mem_ext_arbiter
  import mem_ext_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                          clock,
  input  logic                          reset,
`ifdef MEM_EXT_ARB_PERF_EN
  output logic [NUM_REQ*PERF_CNT_W-1:0] perf_grant_cnt,
  output logic [PERF_CNT_W-1:0]         perf_conflict_cnt,
`endif
  mem_ext_arb_if.slave                  bus
);

  mem_req_t           req [NUM_REQ];
  mem_req_t           w_sel, r_sel;
  logic [NUM_REQ-1:0] w_pool, r_pool, w_gnt, r_gnt;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic               w_issue, r_issue, conflict;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i].write = bus.req_write[i];
      req[i].addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
      req[i].data  = bus.req_data[i*DATA_W +: DATA_W];
      req[i].mask  = bus.req_mask[i*MASK_W +: MASK_W];
    end
  end

  assign w_pool = bus.req_valid & bus.req_write & {NUM_REQ{~reset}};
  assign r_pool = bus.req_valid & ~bus.req_write & {NUM_REQ{~reset}};

  rr_arbiter #(.N(NUM_REQ)) u_w_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (w_pool),
    .advance (w_issue),
    .gnt     (w_gnt)
  );

  rr_arbiter #(.N(NUM_REQ)) u_r_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (r_pool),
    .advance (r_issue),
    .gnt     (r_gnt)
  );

  always_comb begin
    w_sel = '0;
    r_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) w_sel = req[i];
      if (r_gnt[i]) r_sel = req[i];
    end
  end

  // Same-address read loses this cycle so it observes the write next cycle.
  assign w_issue  = |w_gnt;
  assign conflict = w_issue && (|r_gnt) && (r_sel.addr == w_sel.addr);
  assign r_issue  = (|r_gnt) && !conflict;
  assign pend_d   = r_issue ? r_gnt : '0;

  always_ff @(posedge clock) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  always_comb begin
    bus.req_ready  = w_gnt | (r_issue ? r_gnt : '0);
    bus.mem_w_en   = w_issue;
    bus.mem_w_addr = w_sel.addr;
    bus.mem_w_data = w_sel.data;
    bus.mem_w_mask = w_sel.mask;
    bus.mem_r_en   = r_issue;
    bus.mem_r_addr = r_sel.addr;
    bus.resp_valid = reset ? '0 : pend_q;
    bus.resp_data  = bus.mem_r_data;
  end

`ifdef MEM_EXT_ARB_PERF_EN
  logic [PERF_CNT_W-1:0] grant_cnt_q [NUM_REQ];
  logic [PERF_CNT_W-1:0] grant_cnt_d [NUM_REQ];
  logic [PERF_CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i];
      if (bus.req_valid[i] && bus.req_ready[i]) grant_cnt_d[i] = sat_inc(grant_cnt_q[i]);
      perf_grant_cnt[i*PERF_CNT_W +: PERF_CNT_W] = grant_cnt_q[i];
    end
    conflict_cnt_d    = conflict ? sat_inc(conflict_cnt_q) : conflict_cnt_q;
    perf_conflict_cnt = conflict_cnt_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
      conflict_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= grant_cnt_d[i];
      conflict_cnt_q <= conflict_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_ext_arbiter.sv
// Directed table-driven bench for mem_ext_arbiter with a behavioural mem_ext model.
module tb_mem_ext_arbiter;
  import mem_ext_arb_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_ext_arb_if #(.NUM_REQ(2)) bus ();

`ifdef MEM_EXT_ARB_PERF_EN
  logic [2*PERF_CNT_W-1:0] perf_grant_cnt;
  logic [PERF_CNT_W-1:0]   perf_conflict_cnt;
`endif

  mem_ext_arbiter #(.NUM_REQ(2)) dut (
    .clock             (clock),
    .reset             (reset),
`ifdef MEM_EXT_ARB_PERF_EN
    .perf_grant_cnt    (perf_grant_cnt),
    .perf_conflict_cnt (perf_conflict_cnt),
`endif
    .bus               (bus)
  );

  // Behavioural mem_ext: masked write and registered read on the same edge.
  logic [DATA_W-1:0] mem [256];
  logic [DATA_W-1:0] mem_rd;
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem_rd = '0;
  end
  always @(posedge clock) begin
    if (bus.mem_w_en)
      for (int b = 0; b < MASK_W; b++)
        if (bus.mem_w_mask[b]) mem[bus.mem_w_addr[7:0]][b*8 +: 8] <= bus.mem_w_data[b*8 +: 8];
    if (bus.mem_r_en) mem_rd <= mem[bus.mem_r_addr[7:0]];
  end
  assign bus.mem_r_data = mem_rd;

  typedef struct {
    logic [1:0] valid;
    logic [1:0] write;
    logic [7:0] a0, a1, d0, d1;
    logic [1:0] e_ready;
    logic       e_wen, e_ren;
    logic [7:0] e_waddr, e_wbyte, e_raddr;
    logic [1:0] e_resp;
    logic [7:0] e_rbyte;
  } vec_t;

  vec_t vec [21];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else passed++;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [7:0] a0,
                       input logic [7:0] a1, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [MASK_W-1:0] m0);
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = {ADDR_W'(a1), ADDR_W'(a0)};
    bus.req_data  = {{32{d1}}, {32{d0}}};
    bus.req_mask  = {{MASK_W{1'b1}}, m0};
  endtask

  initial begin
    //          valid  write  a0     a1     d0     d1     rdy    wen   ren   waddr  wbyte  raddr  resp   rbyte
    vec[0]  = '{2'b11, 2'b00, 8'h40, 8'h41, 8'h00, 8'h00, 2'b01, 1'b0, 1'b1, 8'h00, 8'h00, 8'h40, 2'b00, 8'h00};
    vec[1]  = '{2'b11, 2'b00, 8'h40, 8'h41, 8'h00, 8'h00, 2'b10, 1'b0, 1'b1, 8'h00, 8'h00, 8'h41, 2'b01, 8'h00};
    vec[2]  = '{2'b11, 2'b00, 8'h40, 8'h41, 8'h00, 8'h00, 2'b01, 1'b0, 1'b1, 8'h00, 8'h00, 8'h40, 2'b10, 8'h00};
    vec[3]  = '{2'b11, 2'b00, 8'h40, 8'h41, 8'h00, 8'h00, 2'b10, 1'b0, 1'b1, 8'h00, 8'h00, 8'h41, 2'b01, 8'h00};
    vec[4]  = '{2'b11, 2'b00, 8'h40, 8'h41, 8'h00, 8'h00, 2'b01, 1'b0, 1'b1, 8'h00, 8'h00, 8'h40, 2'b10, 8'h00};
    vec[5]  = '{2'b11, 2'b00, 8'h40, 8'h41, 8'h00, 8'h00, 2'b10, 1'b0, 1'b1, 8'h00, 8'h00, 8'h41, 2'b01, 8'h00};
    vec[6]  = '{2'b11, 2'b00, 8'h40, 8'h41, 8'h00, 8'h00, 2'b01, 1'b0, 1'b1, 8'h00, 8'h00, 8'h40, 2'b10, 8'h00};
    vec[7]  = '{2'b11, 2'b00, 8'h40, 8'h41, 8'h00, 8'h00, 2'b10, 1'b0, 1'b1, 8'h00, 8'h00, 8'h41, 2'b01, 8'h00};
    vec[8]  = '{2'b01, 2'b01, 8'h10, 8'h00, 8'hA5, 8'h00, 2'b01, 1'b1, 1'b0, 8'h10, 8'hA5, 8'h00, 2'b10, 8'h00};
    vec[9]  = '{2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 2'b01, 1'b0, 1'b1, 8'h00, 8'h00, 8'h10, 2'b00, 8'h00};
    vec[10] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'b01, 8'hA5};
    vec[11] = '{2'b11, 2'b01, 8'h20, 8'h20, 8'h01, 8'h00, 2'b01, 1'b1, 1'b0, 8'h20, 8'h01, 8'h00, 2'b00, 8'h00};
    vec[12] = '{2'b10, 2'b00, 8'h00, 8'h20, 8'h00, 8'h00, 2'b10, 1'b0, 1'b1, 8'h00, 8'h00, 8'h20, 2'b00, 8'h00};
    vec[13] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'b10, 8'h01};
    vec[14] = '{2'b11, 2'b01, 8'h30, 8'h31, 8'h77, 8'h00, 2'b11, 1'b1, 1'b1, 8'h30, 8'h77, 8'h31, 2'b00, 8'h00};
    vec[15] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'b10, 8'h00};
    vec[16] = '{2'b11, 2'b11, 8'h50, 8'h51, 8'h11, 8'h22, 2'b10, 1'b1, 1'b0, 8'h51, 8'h22, 8'h00, 2'b00, 8'h00};
    vec[17] = '{2'b11, 2'b11, 8'h50, 8'h51, 8'h11, 8'h22, 2'b01, 1'b1, 1'b0, 8'h50, 8'h11, 8'h00, 2'b00, 8'h00};
    vec[18] = '{2'b11, 2'b00, 8'h50, 8'h51, 8'h00, 8'h00, 2'b01, 1'b0, 1'b1, 8'h00, 8'h00, 8'h50, 2'b00, 8'h00};
    vec[19] = '{2'b11, 2'b00, 8'h50, 8'h51, 8'h00, 8'h00, 2'b10, 1'b0, 1'b1, 8'h00, 8'h00, 8'h51, 2'b01, 8'h11};
    vec[20] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'b10, 8'h22};

    // Reset held with every requester valid: nothing may be granted or reported.
    drive(2'b11, 2'b01, 8'h40, 8'h41, 8'h5A, 8'h00, '1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("rst_ready", 256'(bus.req_ready), 256'(2'b00));
      check("rst_wen", 256'(bus.mem_w_en), 256'(1'b0));
      check("rst_ren", 256'(bus.mem_r_en), 256'(1'b0));
      check("rst_resp", 256'(bus.resp_valid), 256'(2'b00));
      @(posedge clock);
    end
    #1 reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      drive(vec[i].valid, vec[i].write, vec[i].a0, vec[i].a1, vec[i].d0, vec[i].d1, '1);
      @(negedge clock);
      check($sformatf("v%0d_ready", i), 256'(bus.req_ready), 256'(vec[i].e_ready));
      check($sformatf("v%0d_wen", i), 256'(bus.mem_w_en), 256'(vec[i].e_wen));
      check($sformatf("v%0d_ren", i), 256'(bus.mem_r_en), 256'(vec[i].e_ren));
      check($sformatf("v%0d_resp", i), 256'(bus.resp_valid), 256'(vec[i].e_resp));
      if (vec[i].e_wen) begin
        check($sformatf("v%0d_waddr", i), 256'(bus.mem_w_addr), 256'(vec[i].e_waddr));
        check($sformatf("v%0d_wdata", i), bus.mem_w_data, {32{vec[i].e_wbyte}});
      end
      if (vec[i].e_ren) check($sformatf("v%0d_raddr", i), 256'(bus.mem_r_addr), 256'(vec[i].e_raddr));
      if (vec[i].e_resp != 2'b00)
        check($sformatf("v%0d_rdata", i), bus.resp_data, {32{vec[i].e_rbyte}});
      @(posedge clock);
      #1;
    end

`ifdef MEM_EXT_ARB_PERF_EN
    check("perf_conflict", 256'(perf_conflict_cnt), 256'(32'd1));
    check("perf_grant0", 256'(perf_grant_cnt[31:0]), 256'(32'd10));
    check("perf_grant1", 256'(perf_grant_cnt[63:32]), 256'(32'd8));
`endif

    // Reset in the cycle after a read issue drops the response.
    drive(2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, '1);
    @(negedge clock);
    check("mid_issue_ren", 256'(bus.mem_r_en), 256'(1'b1));
    check("mid_issue_ready", 256'(bus.req_ready), 256'(2'b01));
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("mid_rst_resp", 256'(bus.resp_valid), 256'(2'b00));
    check("mid_rst_ready", 256'(bus.req_ready), 256'(2'b00));
    @(posedge clock);
    #1 reset = 1'b0;
    drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, '1);
    @(negedge clock);
    check("post_rst_resp", 256'(bus.resp_valid), 256'(2'b00));
    @(posedge clock);

    // All-zero mask write is still granted but leaves memory untouched.
    #1 drive(2'b01, 2'b01, 8'h10, 8'h00, 8'hFF, 8'h00, '0);
    @(negedge clock);
    check("zmask_ready", 256'(bus.req_ready), 256'(2'b01));
    check("zmask_wen", 256'(bus.mem_w_en), 256'(1'b1));
    @(posedge clock);
    #1 drive(2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, '1);
    @(negedge clock);
    check("zmask_rd_ready", 256'(bus.req_ready), 256'(2'b01));
    @(posedge clock);
    #1 drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, '1);
    @(negedge clock);
    check("zmask_resp", 256'(bus.resp_valid), 256'(2'b01));
    check("zmask_rdata", bus.resp_data, {32{8'hA5}});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
